// File: rtl/montgomery_reduce_pipe_if.sv
// Stream bundle for the Montgomery reduction pipe: input beat side and
// output beat side, sharing one valid/ready pair in each direction.
interface montgomery_reduce_pipe_if #(
    parameter int WID   = 16,
    parameter int LANES = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*2*WID-1:0]    in_a;
    logic                      in_canon;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*WID-1:0]      out_r;

    // Producer/consumer view (drives beats in, accepts results)
    modport master (
        output in_valid, in_a, in_canon, out_ready,
        input  in_ready, out_valid, out_r
    );

    // Reduction pipe view
    modport slave (
        input  in_valid, in_a, in_canon, out_ready,
        output in_ready, out_valid, out_r
    );
endinterface

// File: rtl/montgomery_reduce_pipe.sv
// Multi-lane, 3-stage signed Montgomery reduction: r = a * 2^-WID mod Q.
// All stages advance together on a single global enable; the canonical
// correction is applied combinationally on the last stage.
module montgomery_reduce_pipe #(
    parameter int WID   = 16,
    parameter int Q     = 3329,
    parameter int QINV  = 62209,
    parameter int LANES = 2
) (
    input logic                     clk,
    input logic                     rst,
    montgomery_reduce_pipe_if.slave bus
);
    localparam logic        [WID-1:0] QINV_W = WID'(QINV);
    localparam logic signed [2*WID:0] Q_U    = (2*WID+1)'(Q);
    localparam logic signed [WID-1:0] Q_R    = WID'(Q);

    logic advance;

    logic s1_valid, s2_valid, s3_valid;
    logic s1_canon, s2_canon, s3_canon;

    logic signed [2*WID-1:0] s1_a [LANES];
    logic signed [2*WID-1:0] s2_a [LANES];
    logic signed [WID-1:0]   s2_t [LANES];
    logic signed [WID-1:0]   s3_r [LANES];

    logic signed [WID-1:0]   t    [LANES];
    logic signed [2*WID:0]   u    [LANES];
    logic signed [WID-1:0]   r    [LANES];

    // A held output beat freezes every stage, bubbles included
    assign advance       = !(s3_valid && !bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = s3_valid;

    // Per-lane arithmetic between stages: t from S1, u and r from S2
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            t[i] = s1_a[i][WID-1:0] * QINV_W;
            u[i] = $signed({s2_a[i][2*WID-1], s2_a[i]})
                 - $signed({{(WID+1){s2_t[i][WID-1]}}, s2_t[i]}) * Q_U;
            r[i] = WID'(u[i] >>> WID);
        end
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_canon <= 1'b0;
            s2_canon <= 1'b0;
            s3_canon <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_a[i] <= '0;
                s2_a[i] <= '0;
                s2_t[i] <= '0;
                s3_r[i] <= '0;
            end
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s1_canon <= bus.in_canon;
            s2_canon <= s1_canon;
            s3_canon <= s2_canon;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_a[i] <= bus.in_a[i*2*WID +: 2*WID];
                s2_a[i] <= s1_a[i];
                s2_t[i] <= t[i];
                s3_r[i] <= r[i];
            end
        end
    end

    // Canonical-mode correction folds negative centred results into [0, Q)
    always_comb begin
        bus.out_r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s3_canon && (s3_r[i] < 0)) begin
                bus.out_r[i*WID +: WID] = s3_r[i] + Q_R;
            end else begin
                bus.out_r[i*WID +: WID] = s3_r[i];
            end
        end
    end
endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Directed bench for montgomery_reduce_pipe: hand-computed vectors,
// scoreboard on output handshakes, stall hold, async reset, mode switching.
module tb_montgomery_reduce_pipe;
    localparam int WID   = 16;
    localparam int Q     = 3329;
    localparam int QINV  = 62209;
    localparam int LANES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    montgomery_reduce_pipe_if #(.WID(WID), .LANES(LANES)) bus ();

    montgomery_reduce_pipe #(
        .WID(WID), .Q(Q), .QINV(QINV), .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Hand-computed vectors: a, centred result, canonical result.
    // Entries 14/15 are outside the legal range; only definedness is checked.
    int a_tab [16] = '{1, 65536, -1, 0, -65536, 65536000, -109051904, 3329,
                       -3329, 2, 65537, -2, 20, -20,
                       int'(32'h7FFF_FFFF), int'(32'h8000_0000)};
    int cen_tab [16] = '{169, 1, -169, 0, -1, 1000, -1664, 0,
                         0, 338, 170, -338, 51, -51, 0, 0};
    int can_tab [16] = '{169, 1, 3160, 0, 3328, 1000, 1665, 0,
                         0, 338, 170, 2991, 51, 3278, 0, 0};

    typedef struct {
        int e0;
        int e1;
        bit known_only;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic                 held_v = 1'b0;
    logic [LANES*WID-1:0] held_r = '0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+2, then advance
    task automatic step(input logic v, input int i0, input int i1,
                        input logic c, input logic ordy);
        exp_t e;
        bus.in_valid  = v;
        bus.in_a      = {a_tab[i1], a_tab[i0]};
        bus.in_canon  = c;
        bus.out_ready = ordy;
        #1;
        check("in_ready", bus.in_ready, !(bus.out_valid && !ordy));
        if (held_v) begin
            check("stall_hold_valid", bus.out_valid, 1);
            check("stall_hold_r", bus.out_r, held_r);
        end
        held_v = 1'b0;
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", bus.out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.known_only) begin
                    check("ooc_defined", $isunknown(bus.out_r), 0);
                end else begin
                    check("lane0", $signed(bus.out_r[WID-1:0]), e.e0);
                    check("lane1", $signed(bus.out_r[2*WID-1:WID]), e.e1);
                end
            end
        end
        if (bus.out_valid && !ordy) begin
            held_v = 1'b1;
            held_r = bus.out_r;
        end
        if (v && bus.in_ready) begin
            e.e0 = c ? can_tab[i0] : cen_tab[i0];
            e.e1 = c ? can_tab[i1] : cen_tab[i1];
            e.known_only = (i0 >= 14) || (i1 >= 14);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) step(1'b0, 0, 0, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [23:0] vpat = 24'b1101_1110_1011_1111_0110_1101;
    logic [23:0] rpat = 24'b1011_0111_1101_0110_1110_0111;

    initial begin
        if (((Q * QINV) % (1 << WID)) != 1)
            $fatal(1, "FAIL qinv_inverse observed=%0d expected=1", (Q * QINV) % (1 << WID));

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_canon  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_r", bus.out_r, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single beat latency: lanes 1 and 65536, centred
        step(1'b1, 0, 1, 1'b0, 1'b1);
        check("lat_n1_valid", bus.out_valid, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("lat_n2_valid", bus.out_valid, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("lat_n3_valid", bus.out_valid, 1);
        drain();

        // -1 / 0 in both modes
        step(1'b1, 2, 3, 1'b0, 1'b1);
        step(1'b1, 2, 3, 1'b1, 1'b1);
        drain();

        // Back-to-back stream over the table, out_ready held high
        for (int k = 0; k < 28; k++) step(1'b1, k % 14, 13 - (k % 14), 1'(k / 3), 1'b1);
        drain();

        // Stalls and input gaps
        for (int k = 0; k < 24; k++)
            step(vpat[k], k % 14, (k * 5 + 3) % 14, 1'(k ^ (k >> 1)), rpat[k]);
        drain();

        // Mode alternation on a = -1
        for (int k = 0; k < 8; k++) step(1'b1, 2, 2, 1'(~k), 1'b1);
        drain();

        // Out-of-contract inputs stay defined
        step(1'b1, 14, 15, 1'b0, 1'b1);
        step(1'b1, 15, 14, 1'b1, 1'b1);
        drain();

        // Asynchronous reset with three beats in flight
        step(1'b1, 0, 1, 1'b0, 1'b1);
        step(1'b1, 5, 6, 1'b1, 1'b1);
        step(1'b1, 9, 10, 1'b0, 1'b1);
        check("pre_reset_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_out_r", bus.out_r, 0);
        exp_q.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        step(1'b1, 12, 13, 1'b1, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
